// File: rtl/pf_ddr3_lanectrl_dly_seq_if.sv
// Command handshake between the training logic (master) and the delay-line sequencer (slave).
interface pf_ddr3_lanectrl_dly_seq_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_LOAD;
    logic       CMD_SEL;
    logic       CMD_DIR;
    logic [7:0] CMD_TAPS;

    modport master (
        output CMD_VALID, CMD_LOAD, CMD_SEL, CMD_DIR, CMD_TAPS,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID, CMD_LOAD, CMD_SEL, CMD_DIR, CMD_TAPS,
        output CMD_READY
    );
endinterface

// File: rtl/pf_ddr3_lanectrl_dly_seq.sv
// Sequences tap-load/tap-move commands into one-cycle lane controller pulses inside an
// HS_IO_CLK_PAUSE window, tracking RX/TX tap positions and aborting on out-of-range.
module pf_ddr3_lanectrl_dly_seq #(
    parameter int PAUSE_PRE_CYCLES  = 2,
    parameter int PAUSE_POST_CYCLES = 2,
    parameter int MOVE_GAP          = 3,
    parameter int TAP_MAX           = 255,
    parameter int RESET_TAP         = 1
) (
    input  logic                          FAB_CLK,
    input  logic                          RESET,
    pf_ddr3_lanectrl_dly_seq_if.slave     cmd,
    output logic                          DELAY_LINE_SEL,
    output logic                          DELAY_LINE_LOAD,
    output logic                          DELAY_LINE_DIRECTION,
    output logic                          DELAY_LINE_MOVE,
    output logic                          HS_IO_CLK_PAUSE,
    input  logic                          RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic                          TX_DELAY_LINE_OUT_OF_RANGE,
    output logic                          DONE,
    output logic                          OOR_ERR,
    output logic [7:0]                    TAPS_MOVED,
    output logic [7:0]                    TAP_POS_RX,
    output logic [7:0]                    TAP_POS_TX
);
    localparam logic [3:0] PRE_LOAD  = 4'(PAUSE_PRE_CYCLES - 1);
    localparam logic [3:0] POST_LOAD = 4'(PAUSE_POST_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(MOVE_GAP - 1);
    localparam logic [7:0] TAP_TOP   = 8'(TAP_MAX);
    localparam logic [7:0] TAP_RST   = 8'(RESET_TAP);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SETUP, ST_PULSE, ST_GAP, ST_POST, ST_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] taps_left_reg, taps_left_next;
    logic       load_reg, load_next;
    logic       sel_reg, sel_next;
    logic       dir_reg, dir_next;
    logic       oor_reg, oor_next;
    logic [7:0] taps_moved_reg, taps_moved_next;
    logic       pause_reg, line_sel_reg, line_dir_reg, move_reg, line_load_reg;
    logic       done_reg, ready_reg;
    logic       pause_next, line_active, pulse_en;
    logic [7:0] tap_pos_reg  [2];
    logic [7:0] tap_pos_next [2];
    logic [1:0] oor_in;

    assign oor_in = {TX_DELAY_LINE_OUT_OF_RANGE, RX_DELAY_LINE_OUT_OF_RANGE};

    function automatic logic [7:0] step_tap(input logic [7:0] pos, input logic ld, input logic up);
        if (ld)
            return TAP_RST;
        else if (up)
            return (pos == TAP_TOP) ? pos : pos + 8'd1;
        else
            return (pos == 8'd0) ? pos : pos - 8'd1;
    endfunction

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        taps_left_next  = taps_left_reg;
        load_next       = load_reg;
        sel_next        = sel_reg;
        dir_next        = dir_reg;
        oor_next        = oor_reg;
        taps_moved_next = taps_moved_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd.CMD_VALID && ready_reg) begin
                    load_next       = cmd.CMD_LOAD;
                    sel_next        = cmd.CMD_SEL;
                    dir_next        = cmd.CMD_DIR;
                    taps_left_next  = cmd.CMD_TAPS;
                    oor_next        = 1'b0;
                    taps_moved_next = 8'd0;
                    // A zero-tap move has nothing to do, so skip the pause window entirely.
                    if (!cmd.CMD_LOAD && cmd.CMD_TAPS == 8'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_PRE;
                        cnt_next   = PRE_LOAD;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_reg == 4'd0) state_next = ST_SETUP;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            ST_SETUP: state_next = ST_PULSE;
            ST_PULSE: begin
                state_next = ST_GAP;
                cnt_next   = GAP_LOAD;
            end
            ST_GAP: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else if (oor_in[sel_reg]) begin
                    oor_next   = 1'b1;
                    state_next = ST_POST;
                    cnt_next   = POST_LOAD;
                end else if (!load_reg && taps_left_reg != 8'd0) begin
                    state_next = ST_PULSE;
                end else begin
                    state_next = ST_POST;
                    cnt_next   = POST_LOAD;
                end
            end
            ST_POST: begin
                if (cnt_reg == 4'd0) state_next = ST_DONE;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_reg.
        pulse_en    = (state_next == ST_PULSE);
        pause_next  = state_next inside {ST_PRE, ST_SETUP, ST_PULSE, ST_GAP, ST_POST};
        line_active = state_next inside {ST_SETUP, ST_PULSE, ST_GAP, ST_POST};
        if (pulse_en && !load_next) begin
            taps_left_next  = taps_left_reg - 8'd1;
            taps_moved_next = taps_moved_reg + 8'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        assign tap_pos_next[gi] = (pulse_en && sel_next == 1'(gi))
                                ? step_tap(tap_pos_reg[gi], load_next, dir_next)
                                : tap_pos_reg[gi];
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            taps_left_reg  <= 8'd0;
            load_reg       <= 1'b0;
            sel_reg        <= 1'b0;
            dir_reg        <= 1'b0;
            oor_reg        <= 1'b0;
            taps_moved_reg <= 8'd0;
            pause_reg      <= 1'b0;
            line_sel_reg   <= 1'b0;
            line_dir_reg   <= 1'b0;
            move_reg       <= 1'b0;
            line_load_reg  <= 1'b0;
            done_reg       <= 1'b0;
            ready_reg      <= 1'b0;
            tap_pos_reg[0] <= TAP_RST;
            tap_pos_reg[1] <= TAP_RST;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            taps_left_reg  <= taps_left_next;
            load_reg       <= load_next;
            sel_reg        <= sel_next;
            dir_reg        <= dir_next;
            oor_reg        <= oor_next;
            taps_moved_reg <= taps_moved_next;
            pause_reg      <= pause_next;
            line_sel_reg   <= line_active & sel_next;
            line_dir_reg   <= line_active & dir_next;
            move_reg       <= pulse_en & ~load_next;
            line_load_reg  <= pulse_en & load_next;
            done_reg       <= (state_next == ST_DONE);
            ready_reg      <= (state_next == ST_IDLE);
            tap_pos_reg[0] <= tap_pos_next[0];
            tap_pos_reg[1] <= tap_pos_next[1];
        end
    end

    assign cmd.CMD_READY            = ready_reg;
    assign DELAY_LINE_SEL           = line_sel_reg;
    assign DELAY_LINE_DIRECTION     = line_dir_reg;
    assign DELAY_LINE_MOVE          = move_reg;
    assign DELAY_LINE_LOAD          = line_load_reg;
    assign HS_IO_CLK_PAUSE          = pause_reg;
    assign DONE                     = done_reg;
    assign OOR_ERR                  = oor_reg;
    assign TAPS_MOVED               = taps_moved_reg;
    assign TAP_POS_RX               = tap_pos_reg[0];
    assign TAP_POS_TX               = tap_pos_reg[1];
endmodule

// File: tb/tb_pf_ddr3_lanectrl_dly_seq.sv
// Randomized bench for the delay-line sequencer against a timeline/tap-position model.
module tb_pf_ddr3_lanectrl_dly_seq;
    logic       FAB_CLK = 1'b0;
    logic       RESET;
    logic       DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
    logic       HS_IO_CLK_PAUSE, DONE, OOR_ERR;
    logic       RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE;
    logic [7:0] TAPS_MOVED, TAP_POS_RX, TAP_POS_TX;

    int checks   = 0;
    int failures = 0;
    int pos [2];

    pf_ddr3_lanectrl_dly_seq_if cmd_if ();

    pf_ddr3_lanectrl_dly_seq dut (
        .FAB_CLK                    (FAB_CLK),
        .RESET                      (RESET),
        .cmd                        (cmd_if),
        .DELAY_LINE_SEL             (DELAY_LINE_SEL),
        .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
        .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_DELAY_LINE_OUT_OF_RANGE),
        .TX_DELAY_LINE_OUT_OF_RANGE (TX_DELAY_LINE_OUT_OF_RANGE),
        .DONE                       (DONE),
        .OOR_ERR                    (OOR_ERR),
        .TAPS_MOVED                 (TAPS_MOVED),
        .TAP_POS_RX                 (TAP_POS_RX),
        .TAP_POS_TX                 (TAP_POS_TX)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {PAUSE, SEL, DIR, MOVE, LOAD, DONE, READY}
    function automatic logic [6:0] out_vec();
        return {HS_IO_CLK_PAUSE, DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
                DELAY_LINE_LOAD, DONE, cmd_if.CMD_READY};
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 64; i++) begin
            if (cmd_if.CMD_READY === 1'b1) return;
            @(negedge FAB_CLK);
        end
        check_eq("ready_timeout", 32'(cmd_if.CMD_READY), 32'd1);
    endtask

    // c: cycle (1-based after accept) at which the selected line's out-of-range goes high; 0 = never
    task automatic run_cmd(input bit ld, input bit sel, input bit dir, input int taps,
                           input int c, input bit oth_hi);
        int p, done_cyc, exp_moved;
        bit exp_oor, zero, pulse, win, act;
        logic [6:0] exp;
        zero    = !ld && taps == 0;
        exp_oor = 1'b0;
        p       = ld ? 1 : taps;
        if (c != 0) begin
            if (ld) exp_oor = (c <= 7);
            else begin
                for (int j = 1; j <= taps; j++) begin
                    if (4 * j + 3 >= c) begin p = j; exp_oor = 1'b1; break; end
                end
            end
        end
        done_cyc  = zero ? 1 : 4 * p + 6;
        exp_moved = ld ? 0 : p;
        if (ld)       pos[sel] = 1;
        else if (dir) pos[sel] = (pos[sel] + p > 255) ? 255 : pos[sel] + p;
        else          pos[sel] = (pos[sel] - p < 0) ? 0 : pos[sel] - p;

        repeat ($urandom_range(0, 3)) @(negedge FAB_CLK);
        wait_ready();
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_LOAD  = ld;
        cmd_if.CMD_SEL   = sel;
        cmd_if.CMD_DIR   = dir;
        cmd_if.CMD_TAPS  = 8'(taps);
        // Out-of-range seen at accept time must not matter.
        if (sel) begin TX_DELAY_LINE_OUT_OF_RANGE = 1'($urandom); RX_DELAY_LINE_OUT_OF_RANGE = oth_hi | 1'($urandom); end
        else     begin RX_DELAY_LINE_OUT_OF_RANGE = 1'($urandom); TX_DELAY_LINE_OUT_OF_RANGE = oth_hi | 1'($urandom); end
        @(negedge FAB_CLK);
        for (int k = 1; k <= done_cyc + 1; k++) begin
            win   = !zero && k >= 1 && k <= 4 * p + 5;
            act   = !zero && k >= 3 && k <= 4 * p + 5;
            pulse = !zero && k >= 4 && k <= 4 * p && (k % 4 == 0);
            exp   = {win, act & sel, act & dir, pulse & ~ld, pulse & ld,
                     1'(k == done_cyc), 1'(k == done_cyc + 1)};
            check_eq($sformatf("ld%0d sel%0d n%0d cyc%0d pins", ld, sel, taps, k), 32'(out_vec()), 32'(exp));
            if (k == 1) begin
                check_eq("cleared_taps_moved", 32'(TAPS_MOVED), 32'd0);
                check_eq("cleared_oor", 32'(OOR_ERR), 32'd0);
            end
            if (k == done_cyc) begin
                check_eq($sformatf("taps_moved n%0d c%0d", taps, c), 32'(TAPS_MOVED), 32'(exp_moved));
                check_eq($sformatf("oor_err n%0d c%0d", taps, c), 32'(OOR_ERR), 32'(exp_oor));
                check_eq("tap_pos_rx", 32'(TAP_POS_RX), 32'(pos[0]));
                check_eq("tap_pos_tx", 32'(TAP_POS_TX), 32'(pos[1]));
                $display("cmd ld=%0d sel=%0d dir=%0d taps=%0d oor_at=%0d -> pulses=%0d oor=%0d rx=%0d tx=%0d",
                         ld, sel, dir, taps, c, p, exp_oor, pos[0], pos[1]);
            end
            // Garbage offered while busy must be ignored; stop before READY returns.
            cmd_if.CMD_VALID = (k < done_cyc) ? 1'($urandom) : 1'b0;
            cmd_if.CMD_LOAD  = 1'($urandom);
            cmd_if.CMD_SEL   = 1'($urandom);
            cmd_if.CMD_DIR   = 1'($urandom);
            cmd_if.CMD_TAPS  = 8'($urandom);
            if (sel) begin
                TX_DELAY_LINE_OUT_OF_RANGE = (c != 0 && k >= c);
                RX_DELAY_LINE_OUT_OF_RANGE = oth_hi | 1'($urandom);
            end else begin
                RX_DELAY_LINE_OUT_OF_RANGE = (c != 0 && k >= c);
                TX_DELAY_LINE_OUT_OF_RANGE = oth_hi | 1'($urandom);
            end
            @(negedge FAB_CLK);
        end
        RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
    endtask

    task automatic reset_mid_move();
        wait_ready();
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_LOAD  = 1'b0;
        cmd_if.CMD_SEL   = 1'b0;
        cmd_if.CMD_DIR   = 1'b1;
        cmd_if.CMD_TAPS  = 8'd5;
        @(negedge FAB_CLK);
        cmd_if.CMD_VALID = 1'b0;
        repeat (5) @(negedge FAB_CLK);
        check_eq("pre_reset_pause", 32'(HS_IO_CLK_PAUSE), 32'd1);
        RESET = 1'b1;
        @(negedge FAB_CLK);
        check_eq("reset_mid pins", 32'(out_vec()), 32'd0);
        check_eq("reset_mid rx", 32'(TAP_POS_RX), 32'd1);
        check_eq("reset_mid tx", 32'(TAP_POS_TX), 32'd1);
        check_eq("reset_mid moved", 32'(TAPS_MOVED), 32'd0);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        check_eq("after_reset pins", 32'(out_vec()), 32'b0000001);
        pos[0] = 1;
        pos[1] = 1;
        $display("reset mid-move -> outputs cleared, ready restored");
    endtask

    initial begin
        int ld, taps, c;
        RESET = 1'b1;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_LOAD  = 1'b0;
        cmd_if.CMD_SEL   = 1'b0;
        cmd_if.CMD_DIR   = 1'b0;
        cmd_if.CMD_TAPS  = 8'd0;
        RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        pos[0] = 1;
        pos[1] = 1;
        repeat (3) @(negedge FAB_CLK);
        check_eq("reset pins", 32'(out_vec()), 32'd0);
        check_eq("reset oor", 32'(OOR_ERR), 32'd0);
        check_eq("reset moved", 32'(TAPS_MOVED), 32'd0);
        check_eq("reset rx", 32'(TAP_POS_RX), 32'd1);
        check_eq("reset tx", 32'(TAP_POS_TX), 32'd1);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        check_eq("ready_after_reset", 32'(cmd_if.CMD_READY), 32'd1);

        run_cmd(1'b0, 1'b0, 1'b1, 3, 0, 1'b0);   // RX +3
        run_cmd(1'b0, 1'b1, 1'b1, 9, 0, 1'b0);   // TX to 10
        run_cmd(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);   // TX load
        run_cmd(1'b0, 1'b0, 1'b1, 5, 9, 1'b0);   // RX abort after 2
        run_cmd(1'b0, 1'b0, 1'b1, 2, 0, 1'b1);   // TX OOR ignored
        run_cmd(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);   // RX load
        run_cmd(1'b0, 1'b0, 1'b0, 4, 0, 1'b0);   // RX -4, saturates at 0
        run_cmd(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);   // zero-tap
        run_cmd(1'b1, 1'b0, 1'b1, 0, 3, 1'b0);   // load with OOR -> abort flag
        reset_mid_move();

        for (int i = 0; i < 30; i++) begin
            ld   = ($urandom % 4 == 0) ? 1 : 0;
            taps = ($urandom % 8 == 0) ? $urandom_range(200, 255) : $urandom_range(0, 6);
            if (ld != 0)
                c = ($urandom % 3 == 0) ? $urandom_range(1, 9) : 0;
            else if (taps != 0 && $urandom % 3 == 0)
                c = $urandom_range(1, 4 * taps + 3);
            else
                c = 0;
            run_cmd(ld != 0, 1'($urandom), 1'($urandom), taps, c, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
